// File: rtl/aes_pkg.sv
// Shared AES sizing constants and the output skid-buffer state type.
package aes_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int AES_KEY128_W    = 128;
    localparam int AES_KEY256_W    = 256;
    localparam int AES128_NUM_KEYS = 11;
    localparam int AES256_NUM_KEYS = 15;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/valid_ready_skid.sv
// Two-entry valid/ready skid buffer; upstream ready is a flop, never a path from downstream ready.
module valid_ready_skid
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = AES_BLOCK_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data
);

    buf_state_t            state;
    logic [DATA_WIDTH-1:0] skid_p1;
    logic                  accept;
    logic                  take;

    assign accept = up_valid && up_ready;
    assign take   = dn_valid && dn_ready;

    // dn_data is the head entry; skid_p1 holds the second beat while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BUF_EMPTY;
            up_ready <= 1'b0;
            dn_valid <= 1'b0;
            dn_data  <= '0;
            skid_p1  <= '0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    up_ready <= 1'b1;
                    if (accept) begin
                        dn_data  <= up_data;
                        dn_valid <= 1'b1;
                        state    <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    up_ready <= 1'b1;
                    if (accept && !take) begin
                        skid_p1  <= up_data;
                        up_ready <= 1'b0;
                        state    <= BUF_TWO;
                    end else if (accept && take) begin
                        dn_data <= up_data;
                    end else if (take) begin
                        dn_valid <= 1'b0;
                        state    <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (take) begin
                        dn_data  <= skid_p1;
                        up_ready <= 1'b1;
                        state    <= BUF_ONE;
                    end
                end
                default: begin
                    dn_valid <= 1'b0;
                    up_ready <= 1'b0;
                    state    <= BUF_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/round_key_adder.sv
// AES AddRoundKey stage: round-key bank with load/clear, XOR of the selected key,
// and a skid-buffered valid/ready output.
module round_key_adder
    import aes_pkg::*;
#(
    parameter int  DATA_WIDTH = AES_BLOCK_W,
    parameter int  KEY_WIDTH  = AES_KEY128_W,
    parameter int  NUM_KEYS   = AES256_NUM_KEYS,
    localparam int IDX_W      = $clog2(NUM_KEYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_wr_en,
    input  logic [IDX_W-1:0]      key_wr_idx,
    input  logic [KEY_WIDTH-1:0]  key_wr_data,
    input  logic                  key_clear,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [IDX_W-1:0]      round_idx_in,
    output logic                  data_valid_out,
    input  logic                  data_ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  key_err_out
);

    localparam int               IW1        = IDX_W + 1;
    localparam logic [IDX_W:0]   NUM_KEYS_X = IW1'(NUM_KEYS);
    localparam bit               IS_256     = (KEY_WIDTH == AES_KEY256_W);

    if (KEY_WIDTH != AES_KEY128_W && KEY_WIDTH != AES_KEY256_W) begin : g_bad_key_width
        $error("round_key_adder: KEY_WIDTH must be 128 or 256");
    end

    logic [DATA_WIDTH-1:0] bank [NUM_KEYS];
    logic [NUM_KEYS-1:0]   loaded;

    logic [DATA_WIDTH-1:0] key_hi;
    logic [DATA_WIDTH-1:0] key_lo;
    logic [IDX_W-1:0]      wr_idx_lo;
    logic [IDX_W:0]        wr_last;
    logic                  wr_ok;
    logic                  wr_fire;

    logic [DATA_WIDTH-1:0] rd_key;
    logic                  rd_loaded;
    logic                  accept;
    logic [DATA_WIDTH-1:0] beat_p0;

    assign key_hi    = DATA_WIDTH'(key_wr_data[KEY_WIDTH-1 -: AES_BLOCK_W]);
    assign key_lo    = DATA_WIDTH'(key_wr_data[AES_BLOCK_W-1:0]);
    assign wr_idx_lo = key_wr_idx + IDX_W'(1);
    // A 256-bit load touches idx and idx+1; the highest slot touched must exist
    assign wr_last   = IS_256 ? ({1'b0, key_wr_idx} + IW1'(1)) : {1'b0, key_wr_idx};
    assign wr_ok     = (wr_last < NUM_KEYS_X);
    assign wr_fire   = key_wr_en && wr_ok;

    // Out-of-range round indices match no slot and therefore read as unloaded
    always_comb begin
        rd_key    = '0;
        rd_loaded = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (round_idx_in == IDX_W'(i)) begin
                rd_key    = bank[i];
                rd_loaded = loaded[i];
            end
        end
    end

    assign accept  = data_valid_in && data_ready_out;
    assign beat_p0 = rd_loaded ? (data_in ^ rd_key) : data_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            if (key_clear) begin
                loaded <= '0;
            end
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (wr_fire && key_wr_idx == IDX_W'(i)) begin
                    bank[i]   <= key_hi;
                    loaded[i] <= 1'b1;
                end else if (wr_fire && IS_256 && wr_idx_lo == IDX_W'(i)) begin
                    bank[i]   <= key_lo;
                    loaded[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_err_out <= 1'b0;
        end else begin
            key_err_out <= (key_clear ? 1'b0 : key_err_out)
                         | (key_wr_en && !wr_ok)
                         | (accept && !rd_loaded);
        end
    end

    // Stage p0 -> p1: keyed beat enters the output skid buffer
    valid_ready_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (data_valid_in),
        .up_ready (data_ready_out),
        .up_data  (beat_p0),
        .dn_valid (data_valid_out),
        .dn_ready (data_ready_in),
        .dn_data  (data_out)
    );

endmodule

// File: tb/tb_round_key_adder.sv
// Randomized and directed bench for round_key_adder against a queue-based reference model.
module tb_round_key_adder;

    localparam int NK = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_wr_en, key_clear, data_valid_in, data_ready_in;
    logic [3:0]   key_wr_idx, round_idx_in;
    logic [127:0] key_wr_data, data_in, data_out;
    logic         data_ready_out, data_valid_out, key_err_out;

    logic         b_wr, b_clr, b_vin, b_rin, b_rdy, b_vout, b_err;
    logic [3:0]   b_widx, b_ridx;
    logic [255:0] b_wdata;
    logic [127:0] b_din, b_dout;

    int n_cmp = 0;
    int n_err = 0;
    int dut_taken = 0;

    logic [127:0] m_bank [NK];
    logic         m_loaded [NK];
    logic         m_err;
    logic         m_rdy;
    logic [127:0] m_q [$];

    always #5 clk = ~clk;

    round_key_adder #(.DATA_WIDTH(128), .KEY_WIDTH(128), .NUM_KEYS(NK)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .key_clear(key_clear),
        .data_valid_in(data_valid_in), .data_ready_out(data_ready_out),
        .data_in(data_in), .round_idx_in(round_idx_in),
        .data_valid_out(data_valid_out), .data_ready_in(data_ready_in),
        .data_out(data_out), .key_err_out(key_err_out)
    );

    round_key_adder #(.DATA_WIDTH(128), .KEY_WIDTH(256), .NUM_KEYS(NK)) dut256 (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(b_wr), .key_wr_idx(b_widx), .key_wr_data(b_wdata),
        .key_clear(b_clr),
        .data_valid_in(b_vin), .data_ready_out(b_rdy),
        .data_in(b_din), .round_idx_in(b_ridx),
        .data_valid_out(b_vout), .data_ready_in(b_rin),
        .data_out(b_dout), .key_err_out(b_err)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < NK; i++) begin
            m_bank[i]   = '0;
            m_loaded[i] = 1'b0;
        end
        m_err = 1'b0;
        m_rdy = 1'b0;
    endtask

    task automatic check_state();
        check_eq("valid_out", 128'(data_valid_out), 128'(m_q.size() > 0));
        check_eq("ready_out", 128'(data_ready_out), 128'(m_rdy));
        check_eq("key_err", 128'(key_err_out), 128'(m_err));
        if (m_q.size() > 0) check_eq("data_out", data_out, m_q[0]);
    endtask

    // One clock: drive at the falling edge, predict the rising edge, check at the next falling edge
    task automatic cycle(input logic wr, input logic [3:0] widx, input logic [127:0] wdata,
                         input logic clr, input logic vin, input logic [127:0] din,
                         input logic [3:0] ridx, input logic rin);
        logic         acc, tk, hit;
        logic [127:0] val;
        key_wr_en = wr; key_wr_idx = widx; key_wr_data = wdata; key_clear = clr;
        data_valid_in = vin; data_in = din; round_idx_in = ridx; data_ready_in = rin;
        if (data_valid_out && rin) dut_taken++;
        acc = vin && m_rdy;
        tk  = (m_q.size() > 0) && rin;
        hit = (ridx < NK) ? m_loaded[ridx] : 1'b0;
        val = hit ? (din ^ m_bank[ridx]) : din;
        if (tk) void'(m_q.pop_front());
        if (acc) m_q.push_back(val);
        m_err = (clr ? 1'b0 : m_err) | (wr && widx >= NK) | (acc && !hit);
        if (clr) for (int i = 0; i < NK; i++) m_loaded[i] = 1'b0;
        if (wr && widx < NK) begin
            m_bank[widx]   = wdata;
            m_loaded[widx] = 1'b1;
        end
        m_rdy = (m_q.size() < 2);
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle(input logic rin);
        cycle(1'b0, 4'd0, '0, 1'b0, 1'b0, '0, 4'd0, rin);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_valid_now", 128'(data_valid_out), 128'(0));
        check_eq("rst_valid256_now", 128'(b_vout), 128'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_data_out", data_out, 128'(0));
        check_eq("rst_ready", 128'(data_ready_out), 128'(0));
        check_eq("rst_err", 128'(key_err_out), 128'(0));
        rst_n = 1'b1;
        #1;
        check_eq("ready_before_edge", 128'(data_ready_out), 128'(0));
    endtask

    task automatic b_beat(input string tag, input logic [3:0] idx, input logic [127:0] din,
                          input logic [127:0] exp);
        b_vin = 1'b1; b_din = din; b_ridx = idx; b_rin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_vin = 1'b0;
        check_eq({tag, "_valid"}, 128'(b_vout), 128'(1));
        check_eq(tag, b_dout, exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] k0, d0, k1, k2, hold;
        logic [255:0] k256;
        int           sent, taken0;
        logic         v, rin;

        rst_n = 1'b0;
        key_wr_en = 0; key_wr_idx = 0; key_wr_data = 0; key_clear = 0;
        data_valid_in = 0; data_in = 0; round_idx_in = 0; data_ready_in = 0;
        b_wr = 0; b_widx = 0; b_wdata = 0; b_clr = 0; b_vin = 0; b_din = 0; b_ridx = 0; b_rin = 1;
        @(negedge clk);
        do_reset();
        idle(1'b1);

        // Basic XOR with the known vector
        k0 = 128'h5468617473206d79204b756e67204675;
        d0 = 128'h54776f204f6e65204e696e652054776f;
        cycle(1'b1, 4'd0, k0, 1'b0, 1'b0, '0, 4'd0, 1'b1);
        cycle(1'b0, 4'd0, '0, 1'b0, 1'b1, d0, 4'd0, 1'b1);
        check_eq("xor_vector", data_out, 128'h001f0e543c4e08596e221b0b4774311a);
        check_eq("xor_no_err", 128'(key_err_out), 128'(0));
        idle(1'b1);

        // Unloaded slot passes data through and flags the error; clear drops the flag
        d0 = rnd128();
        cycle(1'b0, 4'd0, '0, 1'b0, 1'b1, d0, 4'd3, 1'b1);
        check_eq("unloaded_pass", data_out, d0);
        check_eq("unloaded_err", 128'(key_err_out), 128'(1));
        cycle(1'b0, 4'd0, '0, 1'b1, 1'b0, '0, 4'd0, 1'b1);
        check_eq("clear_err", 128'(key_err_out), 128'(0));

        // Same-cycle write and lookup of slot 0 uses the old key
        k1 = rnd128(); k2 = rnd128(); d0 = rnd128();
        cycle(1'b1, 4'd0, k1, 1'b0, 1'b0, '0, 4'd0, 1'b1);
        cycle(1'b1, 4'd0, k2, 1'b0, 1'b1, d0, 4'd0, 1'b1);
        check_eq("hazard_old_key", data_out, d0 ^ k1);
        cycle(1'b0, 4'd0, '0, 1'b0, 1'b1, d0, 4'd0, 1'b1);
        check_eq("hazard_new_key", data_out, d0 ^ k2);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: downstream stalls for cycles 2..5 of an 8-beat stream
        sent = 0;
        taken0 = dut_taken;
        hold = '0;
        for (int c = 0; c < 16; c++) begin
            rin = !(c >= 2 && c <= 5);
            v = (sent < 8);
            if (v && m_rdy) sent++;
            cycle(1'b0, 4'd0, '0, 1'b0, v, rnd128(), 4'd0, rin);
            if (c == 2) hold = m_q[0];
            if (c >= 3 && c <= 5) begin
                check_eq("bp_stable", data_out, hold);
                check_eq("bp_ready_low", 128'(data_ready_out), 128'(0));
            end
        end
        check_eq("bp_count", 128'(dut_taken - taken0), 128'(8));

        // Reset with two beats buffered discards them
        cycle(1'b0, 4'd0, '0, 1'b0, 1'b1, rnd128(), 4'd0, 1'b0);
        cycle(1'b0, 4'd0, '0, 1'b0, 1'b1, rnd128(), 4'd0, 1'b0);
        check_eq("pre_rst_full", 128'(data_ready_out), 128'(0));
        #2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check_eq("post_rst_empty", 128'(data_valid_out), 128'(0));
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), rnd128(),
                  ($urandom_range(0, 40) == 0), ($urandom_range(0, 9) < 7), rnd128(),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        check_eq("drained", 128'(m_q.size()), 128'(0));

        // 256-bit key loads fill two slots; a load reaching past the bank is dropped
        k256 = {rnd128(), rnd128()};
        d0 = rnd128();
        b_wr = 1'b1; b_widx = 4'd13; b_wdata = k256;
        @(posedge clk);
        @(negedge clk);
        b_wr = 1'b0;
        check_eq("k256_no_err", 128'(b_err), 128'(0));
        b_beat("k256_slot13", 4'd13, d0, d0 ^ k256[255:128]);
        b_beat("k256_slot14", 4'd14, d0, d0 ^ k256[127:0]);
        check_eq("k256_still_ok", 128'(b_err), 128'(0));
        b_wr = 1'b1; b_widx = 4'd14; b_wdata = {rnd128(), rnd128()};
        @(posedge clk);
        @(negedge clk);
        b_wr = 1'b0;
        check_eq("k256_drop_err", 128'(b_err), 128'(1));
        b_beat("k256_slot14_kept", 4'd14, d0, d0 ^ k256[127:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
